tick_period_checker: RTL and testbench

//  Checks the periodic one-cycle tick from the upstream delay/tick generator.

---
 rtl/tick_chk_pkg.sv | 19 +
 rtl/tick_interval_cnt.sv | 49 ++++
 rtl/tick_period_checker.sv | 172 +++++++++++++++++
 tb/tb_tick_period_checker.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/tick_chk_pkg.sv
// Shared types and defaults for the tick period checker.
package tick_chk_pkg;

  typedef enum logic [1:0] {IDLE, ACQ, LOCK, FAULT} tchk_state_e;

  localparam int unsigned DEF_EXP_PERIOD = 100001;
  localparam int unsigned DEF_TOL        = 16;
  localparam int unsigned DEF_LOCK_N     = 2;
  localparam int unsigned DEF_CBITS      = 17;

  // True when p lies in [exp_p-tol, exp_p+tol]. The lower bound is written as
  // p+tol >= exp_p so it cannot underflow when tol > exp_p.
  function automatic logic win_ok(input int unsigned p,
                                  input int unsigned exp_p,
                                  input int unsigned tol);
    return ((p + tol) >= exp_p) && (p <= (exp_p + tol));
  endfunction

endpackage

// File: rtl/tick_interval_cnt.sv
// Interval counter for the tick checker: saturating cycle count since the
// last tick, previous-cycle tick for double-tick detection, timeout compare.
module tick_interval_cnt
  import tick_chk_pkg::*;
#(
  parameter int unsigned EXP_PERIOD = DEF_EXP_PERIOD,
  parameter int unsigned TOL        = DEF_TOL,
  parameter int unsigned CBITS      = DEF_CBITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             clr,
  output logic [CBITS-1:0] cnt,
  output logic             dbl,
  output logic             timeout
);

  localparam logic [CBITS-1:0] CMAX = '1;
  localparam logic [CBITS-1:0] TMO  = CBITS'(EXP_PERIOD + TOL + 1);

  logic [CBITS-1:0] cnt_q, cnt_d;
  logic             tick_d_q, tick_d_d;

  // Next count: clr zeroes, a tick restarts at 1, otherwise count up and stick at max.
  always_comb begin
    cnt_d    = cnt_q;
    tick_d_d = tick;
    if (clr)                cnt_d = '0;
    else if (tick)          cnt_d = CBITS'(1);
    else if (cnt_q != CMAX) cnt_d = cnt_q + CBITS'(1);
  end

  // Counter and delayed-tick registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      tick_d_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      tick_d_q <= tick_d_d;
    end
  end

  assign cnt     = cnt_q;
  assign dbl     = tick & tick_d_q;
  assign timeout = (cnt_q == TMO);

endmodule

// File: rtl/tick_period_checker.sv
// Tick period checker: measures cycles between upstream ticks, locks after
// LOCK_N in-window periods, and latches early/late/double-tick faults.
// Optional TICK_STATS_EN adds pmin/pmax tracking of measured periods.
module tick_period_checker
  import tick_chk_pkg::*;
#(
  parameter int unsigned EXP_PERIOD = DEF_EXP_PERIOD,
  parameter int unsigned TOL        = DEF_TOL,
  parameter int unsigned LOCK_N     = DEF_LOCK_N,
  parameter int unsigned CBITS      = DEF_CBITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             clr,
  output logic             locked,
  output logic             fault,
  output logic             err_early,
  output logic             err_late,
  output logic             err_dbl,
  output logic [CBITS-1:0] period_q,
`ifdef TICK_STATS_EN
  output logic             period_vld,
  output logic [CBITS-1:0] pmin,
  output logic [CBITS-1:0] pmax
`else
  output logic             period_vld
`endif
);

  localparam int unsigned GBITS = (LOCK_N < 2) ? 1 : $clog2(LOCK_N + 1);

  logic [CBITS-1:0] cnt;
  logic             dbl, timeout;

  tick_interval_cnt #(
    .EXP_PERIOD (EXP_PERIOD),
    .TOL        (TOL),
    .CBITS      (CBITS)
  ) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .tick    (tick),
    .clr     (clr),
    .cnt     (cnt),
    .dbl     (dbl),
    .timeout (timeout)
  );

  tchk_state_e      state_q, state_d;
  logic [GBITS-1:0] good_q, good_d;
  logic             err_early_q, err_early_d;
  logic             err_late_q, err_late_d;
  logic             err_dbl_q, err_dbl_d;
  logic [CBITS-1:0] period_d;
  logic             period_vld_q, period_vld_d;

  logic in_win, short_p, long_p, active;

  // Classify the period measured on this cycle's tick.
  always_comb begin
    in_win  = win_ok(32'(cnt), EXP_PERIOD, TOL);
    short_p = tick && ((32'(cnt) + TOL) < EXP_PERIOD);
    long_p  = timeout || (tick && !in_win && !short_p);
    active  = (state_q == ACQ) || (state_q == LOCK);
  end

  // FSM next state, sticky flags and period capture.
  always_comb begin
    state_d      = state_q;
    good_d       = good_q;
    err_early_d  = err_early_q;
    err_late_d   = err_late_q;
    err_dbl_d    = err_dbl_q;
    period_d     = period_q;
    period_vld_d = 1'b0;
    if (clr) begin
      // clr wins over a coincident tick; the last period stays visible.
      state_d     = IDLE;
      good_d      = '0;
      err_early_d = 1'b0;
      err_late_d  = 1'b0;
      err_dbl_d   = 1'b0;
    end else begin
      if (dbl) err_dbl_d = 1'b1;
      if (tick && (state_q != IDLE)) begin
        period_d     = cnt;
        period_vld_d = 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (tick) state_d = ACQ;
        end
        ACQ, LOCK: begin
          if (dbl || short_p) begin
            err_early_d = 1'b1;
            state_d     = FAULT;
            good_d      = '0;
          end else if (long_p) begin
            err_late_d = 1'b1;
            state_d    = FAULT;
            good_d     = '0;
          end else if (tick && (state_q == ACQ)) begin
            good_d = good_q + GBITS'(1);
            if (good_d >= GBITS'(LOCK_N)) state_d = LOCK;
          end
        end
        default: ;
      endcase
    end
  end

  // State and flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      good_q       <= '0;
      err_early_q  <= 1'b0;
      err_late_q   <= 1'b0;
      err_dbl_q    <= 1'b0;
      period_q     <= '0;
      period_vld_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      good_q       <= good_d;
      err_early_q  <= err_early_d;
      err_late_q   <= err_late_d;
      err_dbl_q    <= err_dbl_d;
      period_q     <= period_d;
      period_vld_q <= period_vld_d;
    end
  end

  assign locked     = (state_q == LOCK);
  assign fault      = (state_q == FAULT);
  assign err_early  = err_early_q;
  assign err_late   = err_late_q;
  assign err_dbl    = err_dbl_q;
  assign period_vld = period_vld_q;

`ifdef TICK_STATS_EN
  logic [CBITS-1:0] pmin_q, pmin_d, pmax_q, pmax_d;

  // Running min/max of periods measured while acquiring or locked.
  always_comb begin
    pmin_d = pmin_q;
    pmax_d = pmax_q;
    if (clr) begin
      pmin_d = '1;
      pmax_d = '0;
    end else if (tick && active) begin
      if (cnt < pmin_q) pmin_d = cnt;
      if (cnt > pmax_q) pmax_d = cnt;
    end
  end

  // Stats registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pmin_q <= '1;
      pmax_q <= '0;
    end else begin
      pmin_q <= pmin_d;
      pmax_q <= pmax_d;
    end
  end

  assign pmin = pmin_q;
  assign pmax = pmax_q;
`endif

endmodule

// File: tb/tb_tick_period_checker.sv
// Bench for tick_period_checker (EXP_PERIOD=11, TOL=1, LOCK_N=2, CBITS=5).
// Define TICK_STATS_EN to also exercise pmin/pmax.
module tb_tick_period_checker;

  localparam int EXP = 11, TOL = 1, LOCK_N = 2, CB = 5;
  localparam int LO = EXP - TOL, HI = EXP + TOL, TMO = EXP + TOL + 1, CMAX = 31;
  localparam int M_IDLE = 0, M_ACQ = 1, M_LOCK = 2, M_FAULT = 3;

  logic          clk = 1'b0, rst, tick, clr;
  logic          locked, fault, err_early, err_late, err_dbl, period_vld;
  logic [CB-1:0] period_q;
`ifdef TICK_STATS_EN
  logic [CB-1:0] pmin, pmax;
`endif

  tick_period_checker #(.EXP_PERIOD(EXP), .TOL(TOL), .LOCK_N(LOCK_N), .CBITS(CB)) dut (
    .clk(clk), .rst(rst), .tick(tick), .clr(clr),
    .locked(locked), .fault(fault), .err_early(err_early), .err_late(err_late),
    .err_dbl(err_dbl), .period_q(period_q),
`ifdef TICK_STATS_EN
    .period_vld(period_vld), .pmin(pmin), .pmax(pmax)
`else
    .period_vld(period_vld)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
    end
  endtask

  // Reference model: the cycle count since the last tick is derived from
  // absolute cycle numbers rather than a running counter.
  int cyc = 0, ref_c = 0, base = 0, p = 0;
  int m_st = M_IDLE, m_good = 0, m_period = 0, m_pmin = CMAX, m_pmax = 0;
  bit m_prev = 0, m_early = 0, m_late = 0, m_dbl = 0, m_vld = 0, m_ok = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_st = M_IDLE; m_good = 0; m_period = 0; m_pmin = CMAX; m_pmax = 0;
      m_prev = 0; m_early = 0; m_late = 0; m_dbl = 0; m_vld = 0;
      ref_c = cyc + 1; base = 0; m_ok = 1;
    end else begin
      p = base + (cyc - ref_c);
      if (p > CMAX) p = CMAX;
      m_vld = 0;
      if (clr) begin
        m_st = M_IDLE; m_good = 0; m_early = 0; m_late = 0; m_dbl = 0;
        m_pmin = CMAX; m_pmax = 0;
        ref_c = cyc + 1; base = 0;
      end else begin
        if (tick && m_prev) m_dbl = 1;
        if (m_st == M_ACQ || m_st == M_LOCK) begin
          if (tick) begin
            m_period = p; m_vld = 1;
            if (p < m_pmin) m_pmin = p;
            if (p > m_pmax) m_pmax = p;
          end
          if (tick && p < LO) begin
            m_early = 1; m_st = M_FAULT; m_good = 0;
          end else if (p == TMO || (tick && p > HI)) begin
            m_late = 1; m_st = M_FAULT; m_good = 0;
          end else if (tick && m_st == M_ACQ) begin
            m_good++;
            if (m_good >= LOCK_N) m_st = M_LOCK;
          end
        end else if (m_st == M_FAULT) begin
          if (tick) begin m_period = p; m_vld = 1; end
        end else if (tick) begin
          m_st = M_ACQ;
        end
        if (tick) begin ref_c = cyc + 1; base = 1; end
      end
      m_prev = tick;
    end
    cyc++;
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_ok) begin
      chk("outputs", {26'd0, locked, fault, err_early, err_late, err_dbl, period_vld},
          {26'd0, 1'(m_st == M_LOCK), 1'(m_st == M_FAULT), m_early, m_late, m_dbl, m_vld});
      chk("period_q", 32'(period_q), 32'(m_period));
`ifdef TICK_STATS_EN
      chk("pmin", 32'(pmin), 32'(m_pmin));
      chk("pmax", 32'(pmax), 32'(m_pmax));
`endif
    end
  end

  task automatic step(input logic t, input logic c);
    tick = t; clr = c;
    @(posedge clk); #1;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask
  task automatic tk();
    step(1'b1, 1'b0);
  endtask
  // Three ticks spaced EXP cycles from IDLE: lock asserts after the third.
  task automatic acquire();
    tk(); idle(EXP - 1); tk(); idle(EXP - 1); tk();
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; clr = 1'b0;
    idle(3);
    chk("rst_flags", {27'd0, locked, fault, err_early, err_late, err_dbl}, 32'd0);
    chk("rst_period", 32'(period_q), 32'd0);
    rst = 1'b0;

    // Acquire and lock at the nominal period.
    tk(); idle(10); tk(); idle(10);
    chk("pre_lock", 32'(locked), 32'd0);
    tk();
    chk("lock_3rd", 32'(locked), 32'd1);
    chk("lock_period", 32'(period_q), 32'd11);
    chk("lock_errs", {29'd0, err_early, err_late, err_dbl}, 32'd0);
    idle(10); tk();
    chk("lock_4th", 32'(locked), 32'd1);

    // Window edges keep lock.
    idle(9); tk();
    chk("p10_lock", {30'd0, locked, fault}, 32'b10);
    chk("p10_period", 32'(period_q), 32'd10);
    idle(11); tk();
    chk("p12_lock", {30'd0, locked, fault}, 32'b10);
    chk("p12_period", 32'(period_q), 32'd12);
    idle(10); tk();
`ifdef TICK_STATS_EN
    chk("stats_min", 32'(pmin), 32'd10);
    chk("stats_max", 32'(pmax), 32'd12);
`endif

    // Early tick (period 9) faults.
    idle(8); tk();
    chk("early", {29'd0, err_early, fault, locked}, 32'b110);
    // Counting continues in FAULT and period_q still follows ticks.
    idle(4); tk();
    chk("fault_period", 32'(period_q), 32'd5);
    chk("fault_hold", {30'd0, fault, err_late}, 32'b10);

    // clr with a coincident tick returns to IDLE and keeps period_q.
    step(1'b1, 1'b1);
    chk("clr_flags", {27'd0, locked, fault, err_early, err_late, err_dbl}, 32'd0);
    chk("clr_period", 32'(period_q), 32'd5);
`ifdef TICK_STATS_EN
    chk("clr_min", 32'(pmin), 32'd31);
    chk("clr_max", 32'(pmax), 32'd0);
`endif
    step(1'b0, 1'b0);

    // Missing tick: late fault the cycle after cnt reaches 13.
    acquire();
    chk("relock", 32'(locked), 32'd1);
    idle(12);
    chk("late_pre", {30'd0, locked, fault}, 32'b10);
    idle(1);
    chk("late", {29'd0, err_late, fault, locked}, 32'b110);

    // Double tick while locked.
    step(1'b0, 1'b1);
    acquire(); idle(10); tk(); tk();
    chk("dbl", {28'd0, err_dbl, err_early, fault, locked}, 32'b1110);

    // Reset while locked.
    step(1'b0, 1'b1); step(1'b0, 1'b0);
    acquire();
    chk("lock_before_rst", 32'(locked), 32'd1);
    rst = 1'b1;
    idle(1);
    chk("rst_mid", {21'd0, locked, fault, err_early, err_late, err_dbl, period_vld, period_q},
        32'd0);
    rst = 1'b0;
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
